// File: rtl/basic_handshake_pkg.sv
// Shared constants for the buffered valid/busy completer.
// Optional stall counter: BASIC_HANDSHAKE_STALL_CNT_EN.
package basic_handshake_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int DEPTH_DEF  = 4;
  localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);

  localparam int          STALL_W   = 8;
  localparam logic [7:0]  STALL_MAX = 8'hFF;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/basic_handshake_if.sv
// Requester/consumer side bundle of the buffered completer.
// Optional stall counter: BASIC_HANDSHAKE_STALL_CNT_EN.
interface basic_handshake_if #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) ();

  logic                     valid;
  logic [DATA_W-1:0]        data_in;
  logic                     busy;
  logic [DATA_W-1:0]        data_rcvd;
  logic                     rcvd_valid;
  logic                     rcvd_ready;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output valid,
    output data_in,
    output rcvd_ready,
    input  busy,
    input  data_rcvd,
    input  rcvd_valid,
    input  count
  );

  modport slave (
    input  valid,
    input  data_in,
    input  rcvd_ready,
    output busy,
    output data_rcvd,
    output rcvd_valid,
    output count
  );

endinterface

// File: rtl/basic_handshake_fifo_mem.sv
// DEPTH x DATA_W register array, one write port, async read port.
// Optional stall counter: BASIC_HANDSHAKE_STALL_CNT_EN.
module basic_handshake_fifo_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Cleared so the head word reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/basic_handshake_buffered_completer.sv
// Buffered completer: FIFO behind a valid/busy handshake.
// Optional stall counter: BASIC_HANDSHAKE_STALL_CNT_EN.
module basic_handshake_buffered_completer
  import basic_handshake_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  basic_handshake_if.slave  bus
`ifdef BASIC_HANDSHAKE_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_busy;
  logic [CW-1:0]     w_count_next;
  logic              w_push;
  logic              w_pop;
  logic              w_rvalid;
  logic [DATA_W-1:0] w_rdata;

  assign w_rvalid = (r_count != '0);
  assign w_push   = bus.valid & ~r_busy;
  assign w_pop    = w_rvalid & bus.rcvd_ready;

  always_comb begin
    w_count_next = r_count;
    unique case (1'b1)
      (w_push & ~w_pop): w_count_next = r_count + CW'(1);
      (w_pop & ~w_push): w_count_next = r_count - CW'(1);
      default: ;
    endcase
  end

  // busy tracks next-state fullness, so it is high exactly at count==DEPTH.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_busy   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_busy  <= (w_count_next == CW'(DEPTH));
    end
  end

  basic_handshake_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .rstn    (rstn),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign bus.busy       = r_busy;
  assign bus.data_rcvd  = w_rdata;
  assign bus.rcvd_valid = w_rvalid;
  assign bus.count      = r_count;

`ifdef BASIC_HANDSHAKE_STALL_CNT_EN
  logic [STALL_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (bus.valid && r_busy && r_stall_cnt != STALL_MAX) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_basic_handshake_buffered_completer.sv
// Directed bench for the buffered valid/busy completer.
// Optional stall counter: BASIC_HANDSHAKE_STALL_CNT_EN.
module tb_basic_handshake_buffered_completer;

  localparam int DW = 4;
  localparam int DP = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  basic_handshake_if #(.DATA_W(DW), .DEPTH(DP)) bhs ();

`ifdef BASIC_HANDSHAKE_STALL_CNT_EN
  logic [7:0] stall_cnt;
`endif

  basic_handshake_buffered_completer #(
    .DATA_W (DW),
    .DEPTH  (DP)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bhs)
`ifdef BASIC_HANDSHAKE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       r;
    logic       busy;
    logic       rv;
    logic       chkd;
    logic [3:0] data;
    int         cnt;
    int         stall;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    // v, d, r | busy, rvalid, chkd, data, count, stall
    tbl[0]  = '{1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 4'hA, 1, 0};
    tbl[1]  = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0, 0};
    tbl[2]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 1, 0};
    tbl[3]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 2, 0};
    tbl[4]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 3, 0};
    tbl[5]  = '{1'b1, 4'h4, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4, 0};
    tbl[6]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4, 1};
    tbl[7]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4, 2};
    tbl[8]  = '{1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4, 3};
    tbl[9]  = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 3, 4};
    tbl[10] = '{1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 3, 4};
    tbl[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h4, 2, 4};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1, 4};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 0, 4};

    bhs.valid      = 1'b0;
    bhs.data_in    = '0;
    bhs.rcvd_ready = 1'b0;
    tick();
    tick();

    chk("rst_busy",   int'(bhs.busy),       0);
    chk("rst_rvalid", int'(bhs.rcvd_valid), 0);
    chk("rst_count",  int'(bhs.count),      0);
    chk("rst_data",   int'(bhs.data_rcvd),  0);
    rstn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      bhs.valid      = tbl[i].v;
      bhs.data_in    = tbl[i].d;
      bhs.rcvd_ready = tbl[i].r;
      tick();
      chk($sformatf("v%0d_busy", i),   int'(bhs.busy),       int'(tbl[i].busy));
      chk($sformatf("v%0d_rvalid", i), int'(bhs.rcvd_valid), int'(tbl[i].rv));
      chk($sformatf("v%0d_count", i),  int'(bhs.count),      tbl[i].cnt);
      if (tbl[i].chkd)
        chk($sformatf("v%0d_data", i), int'(bhs.data_rcvd), int'(tbl[i].data));
`ifdef BASIC_HANDSHAKE_STALL_CNT_EN
      chk($sformatf("v%0d_stall", i), int'(stall_cnt), tbl[i].stall);
`endif
    end

    // ready on empty must not move pointers
    do_reset();
    bhs.valid      = 1'b0;
    bhs.rcvd_ready = 1'b1;
    tick();
    tick();
    chk("empty_rdy_count", int'(bhs.count), 0);
    bhs.valid      = 1'b1;
    bhs.data_in    = 4'h7;
    bhs.rcvd_ready = 1'b0;
    tick();
    bhs.valid = 1'b0;
    chk("empty_rdy_rvalid", int'(bhs.rcvd_valid), 1);
    chk("empty_rdy_data",   int'(bhs.data_rcvd),  7);

    // steady push/pop at occupancy 2, pointers wrap several times
    do_reset();
    bhs.rcvd_ready = 1'b0;
    bhs.valid      = 1'b1;
    bhs.data_in    = 4'd0;
    tick();
    bhs.data_in = 4'd1;
    tick();
    chk("pp_pre_count", int'(bhs.count), 2);
    bhs.rcvd_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("pp%0d_head", k), int'(bhs.data_rcvd), k);
      bhs.data_in = 4'(k + 2);
      tick();
      chk($sformatf("pp%0d_count", k), int'(bhs.count), 2);
    end
    bhs.valid = 1'b0;
    chk("pp_tail0", int'(bhs.data_rcvd), 10);
    tick();
    chk("pp_tail1", int'(bhs.data_rcvd), 11);
    tick();
    chk("pp_drained", int'(bhs.count), 0);

    // fill, then hold valid long enough to saturate the stall counter
    do_reset();
    bhs.rcvd_ready = 1'b0;
    bhs.valid      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bhs.data_in = 4'(k + 8);
      tick();
    end
    bhs.data_in = 4'hF;
    for (int k = 0; k < 300; k++) tick();
    chk("sat_busy",  int'(bhs.busy),      1);
    chk("sat_count", int'(bhs.count),     4);
    chk("sat_head",  int'(bhs.data_rcvd), 8);
`ifdef BASIC_HANDSHAKE_STALL_CNT_EN
    chk("sat_stall", int'(stall_cnt), 255);
`endif

    // asynchronous reset away from any clock edge while full
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_busy",   int'(bhs.busy),       0);
    chk("arst_rvalid", int'(bhs.rcvd_valid), 0);
    chk("arst_count",  int'(bhs.count),      0);
    chk("arst_data",   int'(bhs.data_rcvd),  0);
`ifdef BASIC_HANDSHAKE_STALL_CNT_EN
    chk("arst_stall", int'(stall_cnt), 0);
`endif
    bhs.valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    chk("post_rst_count", int'(bhs.count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
